// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the execute stage and the mul/div sequencer.
// The stage is the master; the sequencer is the slave.
interface alu_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Unsigned RV32M mul/div sequencer borrowing the shared ALU's ADD/SUB
// one iteration per cycle; shift, carry and compare are done locally.
module alu_muldiv_seq #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_muldiv_seq_if.slave mdu,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_res
);

  localparam int CW = $clog2(ITER);
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state, state_n;
  logic [1:0]      op_q, op_n;
  logic [XLEN-1:0] hi, hi_n;
  logic [XLEN-1:0] lo, lo_n;
  logic [XLEN-1:0] mc, mc_n;
  logic [XLEN-1:0] res, res_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [XLEN:0]   sh;
  logic            carry;
  logic            ge;
  logic            div0;
  logic            last;

  assign div0 = mdu.op[1] && (mdu.b == '0);
  assign last = (cnt == CW'(ITER - 1));

  assign mdu.busy   = (state == RUN);
  assign mdu.done   = (state == DONE);
  assign mdu.result = res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      hi   <= '0;
      lo   <= '0;
      mc   <= '0;
      res  <= '0;
      cnt  <= '0;
    end else begin
      op_q <= op_n;
      hi   <= hi_n;
      lo   <= lo_n;
      mc   <= mc_n;
      res  <= res_n;
      cnt  <= cnt_n;
    end
  end

  // hi/lo/mc hold {hi,lo,mcand} for multiply and {rem,quo,dvsr} for divide
  always_comb begin
    state_n = state;
    op_n    = op_q;
    hi_n    = hi;
    lo_n    = lo;
    mc_n    = mc;
    res_n   = res;
    cnt_n   = cnt;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = ALU_ADD;
    sh      = '0;
    carry   = 1'b0;
    ge      = 1'b0;
    unique case (1'b1)
      (state == RUN): begin
        cnt_n = cnt + 1'b1;
        if (op_q[1]) begin
          sh     = {hi, lo[XLEN-1]};
          alu_op = ALU_SUB;
          alu_a  = sh[XLEN-1:0];
          alu_b  = mc;
          ge     = sh[XLEN] | (sh[XLEN-1:0] >= mc);
          hi_n   = ge ? alu_res : sh[XLEN-1:0];
          lo_n   = {lo[XLEN-2:0], ge};
        end else begin
          alu_a = hi;
          alu_b = lo[0] ? mc : '0;
          carry = (alu_res < hi);
          hi_n  = {carry, alu_res[XLEN-1:1]};
          lo_n  = {alu_res[0], lo[XLEN-1:1]};
        end
        if (last) begin
          state_n = DONE;
          res_n   = op_q[0] ? hi_n : lo_n;
        end
      end
      default: begin
        state_n = IDLE;
        if (mdu.start) begin
          op_n = mdu.op;
          if (div0) begin
            state_n = DONE;
            res_n   = mdu.op[0] ? mdu.a : '1;
          end else begin
            state_n = RUN;
            cnt_n   = '0;
            hi_n    = '0;
            mc_n    = mdu.op[1] ? mdu.b : mdu.a;
            lo_n    = mdu.op[1] ? mdu.a : mdu.b;
          end
        end
      end
    endcase
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Multi-cycle sequencer that computes RV32M unsigned multiply and divide (MUL, MULHU, DIVU, REMU) by driving the core's shared combinational ALU once per cycle. It uses only the ALU's ADD and SUB operations; shifting, carry and compare are handled locally. It sits beside the execute stage and holds the stage through `busy` until `done`. While the sequencer runs, the stage's ALU operand/op muxes select `alu_a`/`alu_b`/`alu_op`.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
ITER, 32, iterations per operation; must equal XLEN.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  launch request; sampled only when not busy
op  input  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU
a  input  32  multiplicand / dividend, unsigned
b  input  32  multiplier / divisor, unsigned
busy  output  1  high while iterating; stage must stall
done  output  1  one-cycle pulse, result valid
result  output  32  registered result, held until next accepted start
alu_a  output  32  ALU operand A
alu_b  output  32  ALU operand B
alu_op  output  4  ALU opcode: 4'b0000 ADD, 4'b1000 SUB
alu_res  input  32  ALU result, same cycle (combinational)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, internal regs=0, iteration count=0. alu_a=0, alu_b=0, alu_op=4'b0000.
- States: IDLE, RUN, DONE. busy=1 only in RUN. done=1 only in DONE.
- IDLE/DONE with start=1 and b!=0 or op[1]=0 (no div-by-zero):
  - latch op, a, b; go to RUN; count=0.
  - MUL/MULHU: hi=0, lo=b, mcand=a.
  - DIV/REM: rem=0, quo=a, dvsr=b.
- IDLE/DONE with start=1, op[1]=1, b=0 (div-by-zero): go directly to DONE. result = 32'hFFFF_FFFF for DIVU, a for REMU. No RUN cycles.
- start in RUN: ignored; operands unchanged.
- RUN, multiply iteration:
  - alu_op=ADD, alu_a=hi, alu_b = lo[0] ? mcand : 0.
  - carry = (alu_res <u hi).
  - {hi,lo} <= {carry, alu_res, lo} >> 1, i.e. the low bit of lo is dropped.
- RUN, divide iteration (restoring):
  - sh = {rem, quo[31]} (33 bits); alu_op=SUB, alu_a=sh[31:0], alu_b=dvsr.
  - ge = sh[32] | !(sh[31:0] <u dvsr).
  - rem <= ge ? alu_res : sh[31:0]; quo <= {quo[30:0], ge}.
- Count increments each RUN cycle. After the cycle with count=ITER-1, go to DONE and load result:
  - MUL: lo; MULHU: hi; DIVU: quo; REMU: rem.
- DONE lasts exactly one cycle, then IDLE, unless start=1 (back-to-back accepted).
- result is updated only on the transition into DONE. It holds through IDLE.
- Latency: start high in cycle N → busy high in cycles N+1..N+32 → done high in cycle N+33. Div-by-zero: done in cycle N+1.
- Outside RUN: alu_a=0, alu_b=0, alu_op=4'b0000. The stage's own mux owns the ALU then.
- Reset mid-operation: abort immediately to reset values. No done pulse. Stale result is not exposed.
- All arithmetic is modulo 2^32 except the 33-bit divide shift and the local carry/compare.

Test Plan:
- MUL a=7, b=6, start in cycle N → busy cycles N+1..N+32; done in N+33 with result=42; alu_op=4'b0000 throughout RUN.
- MULHU a=b=32'hFFFF_FFFF → result=32'hFFFF_FFFE. MUL with same operands → result=32'h0000_0001.
- DIVU a=100, b=7 → result=14. REMU a=100, b=7 → result=2. DIVU a=32'hFFFF_FFFF, b=1 → 32'hFFFF_FFFF. alu_op=4'b1000 in RUN.
- DIVU a=5, b=0 → done in N+1, result=32'hFFFF_FFFF, busy never high. REMU a=5, b=0 → result=5.
- Start MUL 3*4, pulse start with MUL 9*9 at N+10 → second request ignored; done N+33 result=12. Then start in the DONE cycle → accepted, next done 33 cycles later with the new result.
- DIVU 100/7 started, rst_n low at N+15 → busy=0, done=0, result=0 immediately; no done pulse afterwards. A new start after reset completes correctly.
